// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// Define UART_TX_HOLD_EN to add a one-entry hold register for back-to-back frames.
module uart_tx #(
  parameter int unsigned OSR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_clk,
  input  logic       tx_en,
  input  logic       no_parity,
  input  logic       ev_parity,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e     state_q, state_d;
  logic       sclk_q;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       np_q, np_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       tick, tx_pos, bit_end, accept;
  logic       load_new, new_par;

  assign tick    = sample_clk & ~sclk_q;
  assign tx_pos  = tx_en & tick;
  assign bit_end = tx_pos && (tick_q == 4'(OSR - 1));
  assign accept  = tx_start & tx_ready;
  assign new_par = ev_parity ? ^tx_data : ~^tx_data;

  assign txd     = txd_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

`ifdef UART_TX_HOLD_EN
  logic       hfull_q, hfull_d;
  logic [7:0] hdata_q, hdata_d;
  logic       hnp_q, hnp_d;
  logic       hpar_q, hpar_d;
  logic       load_hold;

  assign tx_ready = tx_en & ~hfull_q;
`else
  assign tx_ready = tx_en & (state_q == IDLE);
`endif

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    np_d     = np_q;
    par_d    = par_q;
    done_d   = 1'b0;
    load_new = 1'b0;
`ifdef UART_TX_HOLD_EN
    hfull_d   = hfull_q;
    hdata_d   = hdata_q;
    hnp_d     = hnp_q;
    hpar_d    = hpar_q;
    load_hold = 1'b0;
`endif
    if (!tx_en) begin
      state_d = IDLE;
      tick_d  = '0;
      bit_d   = '0;
`ifdef UART_TX_HOLD_EN
      hfull_d = 1'b0;
`endif
    end else begin
      if (tx_pos && state_q != IDLE)
        tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
      unique case (state_q)
        IDLE: if (accept) load_new = 1'b1;
        START: if (bit_end) state_d = DATA;
        DATA: if (bit_end) begin
          shift_d = {1'b1, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = np_q ? STOP : PARITY;
        end
        PARITY: if (bit_end) state_d = STOP;
        STOP: if (bit_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef UART_TX_HOLD_EN
          if (hfull_q) load_hold = 1'b1;
          else if (accept) load_new = 1'b1;
`endif
        end
        default: state_d = IDLE;
      endcase
`ifdef UART_TX_HOLD_EN
      // A byte accepted mid-frame waits in the hold register.
      if (accept && state_q != IDLE && !load_new) begin
        hfull_d = 1'b1;
        hdata_d = tx_data;
        hnp_d   = no_parity;
        hpar_d  = new_par;
      end
      if (load_hold) begin
        shift_d = hdata_q;
        np_d    = hnp_q;
        par_d   = hpar_q;
        bit_d   = '0;
        tick_d  = '0;
        state_d = START;
        hfull_d = 1'b0;
      end
`endif
      if (load_new) begin
        shift_d = tx_data;
        np_d    = no_parity;
        par_d   = new_par;
        bit_d   = '0;
        tick_d  = '0;
        state_d = START;
      end
    end
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    sclk_q <= sample_clk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= 8'hFF;
      np_q    <= 1'b1;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      np_q    <= np_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hfull_q <= 1'b0;
      hdata_q <= '0;
      hnp_q   <= 1'b1;
      hpar_q  <= 1'b0;
    end else begin
      hfull_q <= hfull_d;
      hdata_q <= hdata_d;
      hnp_q   <= hnp_d;
      hpar_q  <= hpar_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: directed frames, decoded from txd by a
// tick-counting monitor and compared against queued expectations.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_clk = 1'b0;
  logic       tx_en = 1'b1;
  logic       no_parity = 1'b1;
  logic       ev_parity = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd, tx_ready, tx_busy, tx_done;

  uart_tx #(.OSR(16)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .tx_en(tx_en), .no_parity(no_parity), .ev_parity(ev_parity),
    .tx_start(tx_start), .tx_data(tx_data),
    .txd(txd), .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // sample_clk changes 2ns after a posedge, one tick every 4 clks
  initial forever begin
    repeat (2) @(posedge clk);
    #2 sample_clk = ~sample_clk;
  end

  typedef struct {
    logic [7:0] data;
    logic       np;
    logic       par;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic        tick_tb = 1'b0;
  logic        sq_tb = 1'b0;
  bit          mon_active = 1'b0;
  bit          abort_ok = 1'b0;
  int          tcnt = 0;
  logic [10:0] v0, v15;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    tick_tb = sample_clk & ~sq_tb;
    sq_tb   = sample_clk;
  end

  task automatic check_frame(input int nb);
    exp_t        e;
    logic [10:0] eb, m;
    if (q.size() == 0) begin
      chk("unexpected_frame", {24'h0, v0[8:1]}, 32'hFFFF_FFFF);
      return;
    end
    e  = q.pop_front();
    eb = {1'b1, (e.np ? 1'b1 : e.par), e.data, 1'b0};
    m  = (nb == 11) ? 11'h7FF : 11'h3FF;
    chk("data_byte", {24'h0, v0[8:1]}, {24'h0, e.data});
    chk("bits_at_start", {21'h0, v0 & m}, {21'h0, eb & m});
    chk("bits_at_end", {21'h0, v15 & m}, {21'h0, eb & m});
    chk("done_pulse", {31'h0, tx_done}, 32'd1);
    if (!e.np) chk("parity_bit", {31'h0, v0[9]}, {31'h0, e.par});
  endtask

  initial begin : monitor
    int nb, k, r;
    bit ended;
    forever begin
      @(negedge clk);
      ended = 1'b0;
      if (mon_active && tick_tb) begin
        tcnt++;
        nb = (q.size() > 0 && !q[0].np) ? 11 : 10;
        if (tcnt == 16 * nb) begin
          ended = 1'b1;
          mon_active = 1'b0;
          check_frame(nb);
        end else begin
          k = tcnt / 16;
          r = tcnt % 16;
          if (r == 0) v0[k] = txd;
          if (r == 15) v15[k] = txd;
        end
      end
      if (mon_active && !tx_busy) begin
        mon_active = 1'b0;
        if (!abort_ok) chk("busy_dropped", 32'd0, 32'd1);
      end
      if (tx_done && !ended)
        chk("spurious_done", 32'd1, 32'd0);
      if (!mon_active && txd == 1'b0) begin
        mon_active = 1'b1;
        tcnt = 0;
        v0 = '1;
        v15 = '1;
        v0[0] = txd;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic np, input logic ev,
                      input logic par_exp, input bit push);
    int t = 0;
    while (!tx_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) chk("ready_timeout", 32'd0, 32'd1);
    tx_data   = d;
    no_parity = np;
    ev_parity = ev;
    tx_start  = 1'b1;
    if (push) q.push_back('{d, np, par_exp});
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || mon_active || tx_busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("idle_timeout", 32'd0, 32'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_tcnt(input int n);
    int t = 0;
    while (!(mon_active && tcnt >= n) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("tcnt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'h0, txd}, 32'd1);
    chk("rst_busy", {31'h0, tx_busy}, 32'd0);
    chk("rst_ready", {31'h0, tx_ready}, 32'd1);
    chk("rst_done", {31'h0, tx_done}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send(8'h55, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_idle();
    send(8'hA3, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();
    send(8'hA3, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle();

`ifndef UART_TX_HOLD_EN
    send(8'hF0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("ready_low_busy", {31'h0, tx_ready}, 32'd0);
    tx_data  = 8'h12;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
`else
    begin
      int t = 0;
      send(8'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
      send(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("hold_full_ready", {31'h0, tx_ready}, 32'd0);
      while (!tx_done && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_txd_low", {31'h0, txd}, 32'd0);
      chk("b2b_busy", {31'h0, tx_busy}, 32'd1);
      @(negedge clk);
      chk("hold_ready_back", {31'h0, tx_ready}, 32'd1);
      wait_idle();
    end
`endif

    abort_ok = 1'b1;
    send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_tcnt(16 * 5 + 8);
    tx_en = 1'b0;
    @(negedge clk);
    chk("abort_txd", {31'h0, txd}, 32'd1);
    chk("abort_busy", {31'h0, tx_busy}, 32'd0);
    chk("abort_ready", {31'h0, tx_ready}, 32'd0);
    tx_en = 1'b1;
    repeat (100) @(negedge clk);
    abort_ok = 1'b0;
    send(8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();

    abort_ok = 1'b1;
    send(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_tcnt(16 * 9 + 8);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_txd", {31'h0, txd}, 32'd1);
    chk("rst_mid_busy", {31'h0, tx_busy}, 32'd0);
    chk("rst_mid_ready", {31'h0, tx_ready}, 32'd1);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    abort_ok = 1'b0;
    send(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle();

    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART block; the transmit-side counterpart to the oversampling receiver.
- Takes a byte over a single-cycle strobe and serialises it on txd as one frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Bit timing comes from the shared oversample clock (sample_clk) at OSR ticks per bit, so the baud rate is the same as the receiver's.

Parameters:
- OSR, 16, sample ticks per bit; legal range 4..16; bit-tick counter is 4 bits wide.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sample_clk  input  1  oversample clock (level, slow relative to clk); one tick per rising edge
- tx_en  input  1  transmitter enable; low aborts and holds idle
- no_parity  input  1  1 = no parity bit
- ev_parity  input  1  1 = even parity, 0 = odd (ignored when no_parity = 1)
- tx_start  input  1  one-cycle write strobe; accepted only when tx_ready = 1
- tx_data  input  8  byte to send, captured on accept
- txd  output  1  serial line, idles high
- tx_ready  output  1  new byte may be written this cycle
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-clk pulse at end of stop bit

Behaviour:
- Tick detection:
  - sample_clk is registered on clk; tick = sample_clk & ~sample_clk_q.
  - tx_pos = tx_en & tick.
- Reset (rst = 1 at posedge clk): state IDLE, txd = 1, tx_busy = 0, tx_done = 0, tx_ready = 1, counters 0, shift register 0xFF.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd = 1.
  - tx_start & tx_ready & tx_en: latch tx_data, no_parity, ev_parity; bit_cnt = 0; tick_cnt = 0; go to START.
  - txd goes low on the next clk.
- Bit timing:
  - Each tx_pos increments tick_cnt.
  - At tx_pos with tick_cnt == OSR-1: tick_cnt = 0, advance to the next bit.
  - The start bit therefore lasts between OSR-1 and OSR tick periods, depending on accept phase; all later bits last exactly OSR ticks.
- START: txd = 0. At bit end, go to DATA.
- DATA:
  - txd = shift[0]; at each bit end, shift right.
  - bit_cnt counts 0..7.
  - At bit end with bit_cnt == 7: go to PARITY if the latched no_parity = 0, else to STOP.
- PARITY:
  - txd = ^data_latched for even parity, ~^data_latched for odd.
  - At bit end, go to STOP.
- STOP:
  - txd = 1.
  - At bit end: tx_done = 1 for exactly one clk, then go to IDLE (or START if the hold buffer is loaded; see Optional Feature).
- Status outputs:
  - tx_busy = 1 in every state except IDLE.
  - tx_ready = 1 in IDLE with tx_en = 1; without the feature it is 0 during a frame.
- tx_start while tx_ready = 0: ignored; no state change, data dropped.
- Config changes mid-frame: no_parity/ev_parity have no effect on the current frame because they are latched at accept.
- tx_en low at any cycle:
  - Next clk: state IDLE, txd = 1, counters cleared, hold buffer emptied, no tx_done.
  - A frame cut short this way is not resumed.
- rst mid-frame: same result as reset, txd = 1 next clk.
- Simultaneous tx_start and a tick in IDLE: the accept takes priority; the tick is not counted.

Optional Feature:
- Macro: UART_TX_HOLD_EN.
- Defined: adds a one-entry hold register (data plus parity config).
  - tx_ready = tx_en & ~hold_full.
  - Accepting a byte while busy loads the hold register.
  - At the end of STOP with hold_full: tx_done pulses, the hold contents move to the shift register, the state goes directly to START with tick_cnt = 0, and txd goes low next clk. There is no idle gap beyond one clk.
  - hold_full clears on that transfer.
  - Accepting a byte in IDLE with the hold register empty starts the frame directly.
- Undefined: no hold register; tx_ready = tx_en & (state == IDLE).

Test Plan:
- 0x55, no_parity = 1 -> txd shows 0,1,0,1,0,1,0,1,0,1 (start, d0..d7, stop); each bit after the start lasts 16 ticks; one tx_done pulse; tx_busy high throughout the frame.
- 0xA3, no_parity = 0: with ev_parity = 1 -> parity bit 0; with ev_parity = 0 -> parity bit 1; the frame is 11 bits long.
- tx_start with 0x12 while busy sending 0xF0 (feature off) -> 0x12 is dropped; only 0xF0 is seen on txd; tx_ready = 0 during the frame.
- Feature on: write 0x0F then 0xC3 back to back -> two frames with no idle bit between them; two tx_done pulses; tx_ready returns to 1 after the hold register transfers.
- tx_en deasserted during DATA bit 4 -> txd = 1 next clk; no tx_done; state IDLE; a later 0x81 is sent correctly.
- rst asserted mid-PARITY -> txd = 1, tx_busy = 0, tx_ready = 1 next clk; no spurious tx_done.
